// File: rtl/coord_pkg.sv
// Shared definitions for the coordinate packet framing controller:
// FSM state encoding, error codes, default sync marker and checksum helper.
package coord_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        GET_XL  = 3'd1,
        GET_XH  = 3'd2,
        GET_YL  = 3'd3,
        GET_YH  = 3'd4,
        GET_CHK = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] xor_checksum(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return b0 ^ b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/coord_packet_ctrl_rx_timeout_timer.sv
// Inter-byte receive timer: counts idle cycles while a packet is in flight and
// flags expiry on the last allowed cycle unless a byte arrives that same cycle.
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;
    logic          at_last_s;

    assign at_last_s = (count_r == LAST);
    // A byte arriving on the expiry cycle takes precedence over the abort.
    assign expired   = enable && !clear && at_last_s;

    // Idle-cycle counter, held at zero outside a packet and restarted by each byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear || !enable || at_last_s) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1'b1);
        end
    end

endmodule

// File: rtl/coord_packet_ctrl.sv
// Framing controller: hunts for the sync byte, collects a 4-byte coordinate
// payload plus XOR checksum, validates it and commits x/y to the cursor datapath.
module coord_packet_ctrl
    import coord_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         X_MAX          = 639,
    parameter int         Y_MAX          = 479,
    parameter int         RESET_X        = 240,
    parameter int         RESET_Y        = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done_rx,
    input  logic [7:0] byte_rx,
    output logic [9:0] x_coordinate,
    output logic [9:0] y_coordinate,
    output logic       coord_valid,
    output logic       pkt_error,
    output logic [1:0] err_code,
    output logic [7:0] pkt_count
);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] xl_r;
    logic [7:0] xh_r;
    logic [7:0] yl_r;
    logic [7:0] yh_r;
    logic [9:0] x_new_s;
    logic [9:0] y_new_s;
    logic       chk_ok_s;
    logic       range_bad_s;
    logic       commit_s;
    logic       reject_s;
    logic [1:0] err_code_s;
    logic       timer_en_s;
    logic       expired_s;

    assign timer_en_s = (state_r != HUNT);

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (done_rx),
        .enable (timer_en_s),
        .expired(expired_s)
    );

    // The checksum byte is live on byte_rx during GET_CHK, so it is compared unregistered.
    assign x_new_s     = {xh_r[1:0], xl_r};
    assign y_new_s     = {yh_r[1:0], yl_r};
    assign chk_ok_s    = (byte_rx == xor_checksum(xl_r, xh_r, yl_r, yh_r));
    assign range_bad_s = (xh_r[7:2] != 6'd0) || (yh_r[7:2] != 6'd0) ||
                         (x_new_s > 10'(X_MAX)) || (y_new_s > 10'(Y_MAX));

    // Next-state and packet verdict; only a received byte or a timeout moves the FSM.
    always_comb begin
        state_s    = state_r;
        commit_s   = 1'b0;
        reject_s   = 1'b0;
        err_code_s = err_code;
        if (done_rx) begin
            case (state_r)
                HUNT: begin
                    if (byte_rx == SYNC_BYTE) begin
                        state_s = GET_XL;
                    end else begin
                        state_s = HUNT;
                    end
                end
                GET_XL:  state_s = GET_XH;
                GET_XH:  state_s = GET_YL;
                GET_YL:  state_s = GET_YH;
                GET_YH:  state_s = GET_CHK;
                GET_CHK: begin
                    state_s = HUNT;
                    if (!chk_ok_s) begin
                        reject_s   = 1'b1;
                        err_code_s = ERR_CHK;
                    end else if (range_bad_s) begin
                        reject_s   = 1'b1;
                        err_code_s = ERR_RANGE;
                    end else begin
                        commit_s   = 1'b1;
                    end
                end
                default: state_s = HUNT;
            endcase
        end else if (expired_s) begin
            state_s    = HUNT;
            reject_s   = 1'b1;
            err_code_s = ERR_TIMEOUT;
        end else begin
            state_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Payload capture, one byte per collecting state.
    always_ff @(posedge clk) begin
        if (reset) begin
            xl_r <= 8'd0;
            xh_r <= 8'd0;
            yl_r <= 8'd0;
            yh_r <= 8'd0;
        end else if (done_rx) begin
            case (state_r)
                GET_XL:  xl_r <= byte_rx;
                GET_XH:  xh_r <= byte_rx;
                GET_YL:  yl_r <= byte_rx;
                GET_YH:  yh_r <= byte_rx;
                default: begin end
            endcase
        end else begin
            xl_r <= xl_r;
        end
    end

    // Registered outputs: strobes, sticky error code, coordinates and packet count.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_coordinate <= 10'(RESET_X);
            y_coordinate <= 10'(RESET_Y);
            coord_valid  <= 1'b0;
            pkt_error    <= 1'b0;
            err_code     <= ERR_NONE;
            pkt_count    <= 8'd0;
        end else begin
            coord_valid <= commit_s;
            pkt_error   <= reject_s;
            err_code    <= err_code_s;
            if (commit_s) begin
                x_coordinate <= x_new_s;
                y_coordinate <= y_new_s;
                pkt_count    <= pkt_count + 8'd1;
            end else begin
                x_coordinate <= x_coordinate;
            end
        end
    end

endmodule
